// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) line-memory arbiter.
// Round-robin grant, IDLE/BUSY/DONE sequencing, fully registered outputs.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state_q;
   logic              gnt_d_q;
   logic              last_d_q;
   logic              op_wr_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic [LINE_W-1:0] mem_wdata_q;
   logic              i_resp_q;
   logic              d_resp_q;
   logic [LINE_W-1:0] i_rdata_q;
   logic [LINE_W-1:0] d_rdata_q;

   logic              i_req;
   logic              d_req;
   logic              gnt_d_d;
   logic              op_wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [LINE_W-1:0] wdata_d;

   // Pick the round-robin winner and mux its request fields
   always_comb begin
      i_req   = i_read | i_write;
      d_req   = d_read | d_write;
      gnt_d_d = d_req & (~i_req | ~last_d_q);
      op_wr_d = gnt_d_d ? d_write : i_write;
      addr_d  = gnt_d_d ? d_address : i_address;
      wdata_d = gnt_d_d ? d_wdata : i_wdata;
   end

   // Sequencer: latch on grant, wait for memory, pulse resp once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         gnt_d_q       <= 1'b0;
         last_d_q      <= 1'b1;
         op_wr_q       <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         i_resp_q      <= 1'b0;
         d_resp_q      <= 1'b0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
      end else begin
         i_resp_q <= 1'b0;
         d_resp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_req | d_req) begin
                  gnt_d_q       <= gnt_d_d;
                  last_d_q      <= gnt_d_d;
                  op_wr_q       <= op_wr_d;
                  mem_read_q    <= ~op_wr_d;
                  mem_write_q   <= op_wr_d;
                  mem_address_q <= addr_d;
                  mem_wdata_q   <= wdata_d;
                  state_q       <= BUSY;
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (!op_wr_q) begin
                     if (gnt_d_q) d_rdata_q <= mem_rdata;
                     else         i_rdata_q <= mem_rdata;
                  end
                  i_resp_q <= ~gnt_d_q;
                  d_resp_q <= gnt_d_q;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_resp      = i_resp_q;
   assign d_resp      = d_resp_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_read, i_write, d_read, d_write;
   logic [AW-1:0] i_address, d_address;
   logic [LW-1:0] i_wdata, d_wdata;
   logic          i_resp, d_resp;
   logic [LW-1:0] i_rdata, d_rdata;
   logic          mem_read, mem_write, mem_resp;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata, mem_rdata;

   int n_chk = 0;
   int n_fail = 0;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write),
      .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      i_read = 0; i_write = 0; d_read = 0; d_write = 0;
      i_address = '0; d_address = '0;
      i_wdata = '0; d_wdata = '0;
      mem_resp = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
      n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
      n_chk++; if (mem_address !== '0) begin n_fail++; $display("FAIL rst_mem_address got %h exp 0", mem_address); end
      n_chk++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
      n_chk++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL rst_i_resp got %b exp 0", i_resp); end
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL rst_d_resp got %b exp 0", d_resp); end
      n_chk++; if (i_rdata !== '0) begin n_fail++; $display("FAIL rst_i_rdata got %h exp 0", i_rdata); end
      n_chk++; if (d_rdata !== '0) begin n_fail++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
   endtask

   task automatic test_single_read();
      i_read = 1; i_address = 16'h0040;
      tick();
      n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL single_mem_read got %b exp 1", mem_read); end
      n_chk++; if (mem_address !== 16'h0040) begin n_fail++; $display("FAIL single_addr got %h exp 0040", mem_address); end
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL single_d_resp_c1 got %b exp 0", d_resp); end
      mem_resp = 1; mem_rdata = 128'hA5;
      tick();
      mem_resp = 0; mem_rdata = '1;
      n_chk++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL single_i_resp got %b exp 1", i_resp); end
      n_chk++; if (i_rdata !== 128'hA5) begin n_fail++; $display("FAIL single_i_rdata got %h exp a5", i_rdata); end
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL single_d_resp_c2 got %b exp 0", d_resp); end
      n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL single_done_read got %b exp 0", mem_read); end
      tick();
      i_read = 0;
      n_chk++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL single_resp_pulse got %b exp 0", i_resp); end
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL single_d_resp_c3 got %b exp 0", d_resp); end
      tick();
   endtask

   task automatic test_tie();
      do_reset();
      i_read = 1; i_address = 16'h0100;
      d_write = 1; d_address = 16'h0200; d_wdata = 128'h77;
      tick();
      n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL tie1_read got %b exp 1", mem_read); end
      n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL tie1_write got %b exp 0", mem_write); end
      n_chk++; if (mem_address !== 16'h0100) begin n_fail++; $display("FAIL tie1_addr got %h exp 0100", mem_address); end
      mem_resp = 1; mem_rdata = 128'h11;
      tick();
      mem_resp = 0;
      n_chk++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL tie1_i_resp got %b exp 1", i_resp); end
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL tie1_d_resp got %b exp 0", d_resp); end
      tick();
      i_read = 0;
      n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL tie_idle_write got %b exp 0", mem_write); end
      tick();
      n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL tie2_write got %b exp 1", mem_write); end
      n_chk++; if (mem_address !== 16'h0200) begin n_fail++; $display("FAIL tie2_addr got %h exp 0200", mem_address); end
      n_chk++; if (mem_wdata !== 128'h77) begin n_fail++; $display("FAIL tie2_wdata got %h exp 77", mem_wdata); end
      mem_resp = 1;
      tick();
      mem_resp = 0;
      n_chk++; if (d_resp !== 1'b1) begin n_fail++; $display("FAIL tie2_d_resp got %b exp 1", d_resp); end
      n_chk++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL tie2_i_resp got %b exp 0", i_resp); end
      tick();
      d_write = 0;
      i_read = 1; d_read = 1;
      tick();
      n_chk++; if (mem_address !== 16'h0100) begin n_fail++; $display("FAIL tie3_addr got %h exp 0100", mem_address); end
      mem_resp = 1; mem_rdata = 128'h22;
      tick();
      mem_resp = 0;
      n_chk++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL tie3_i_resp got %b exp 1", i_resp); end
      tick();
      i_read = 0;
      tick();
      n_chk++; if (mem_address !== 16'h0200) begin n_fail++; $display("FAIL tie4_addr got %h exp 0200", mem_address); end
      mem_resp = 1; mem_rdata = 128'h33;
      tick();
      mem_resp = 0;
      n_chk++; if (d_rdata !== 128'h33) begin n_fail++; $display("FAIL tie4_d_rdata got %h exp 33", d_rdata); end
      tick();
      d_read = 0;
      tick();
   endtask

   task automatic test_slow();
      int hi;
      hi = 0;
      d_read = 1; d_address = 16'h0300;
      tick();
      for (int k = 0; k < 6; k++) begin
         if (mem_read === 1'b1 && mem_address === 16'h0300) hi++;
         n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL slow_early_resp got %b exp 0", d_resp); end
         mem_resp = (k == 5);
         mem_rdata = 128'hBEEF;
         tick();
      end
      mem_resp = 0;
      n_chk++; if (hi !== 6) begin n_fail++; $display("FAIL slow_read_cycles got %0d exp 6", hi); end
      n_chk++; if (d_resp !== 1'b1) begin n_fail++; $display("FAIL slow_d_resp got %b exp 1", d_resp); end
      n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL slow_done_read got %b exp 0", mem_read); end
      n_chk++; if (d_rdata !== 128'hBEEF) begin n_fail++; $display("FAIL slow_d_rdata got %h exp beef", d_rdata); end
      tick();
      d_read = 0;
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL slow_pulse got %b exp 0", d_resp); end
      tick();
   endtask

   task automatic test_churn();
      i_read = 1; i_address = 16'h0040;
      tick();
      i_address = 16'h1230;
      n_chk++; if (mem_address !== 16'h0040) begin n_fail++; $display("FAIL churn_c1 got %h exp 0040", mem_address); end
      tick();
      n_chk++; if (mem_address !== 16'h0040) begin n_fail++; $display("FAIL churn_c2 got %h exp 0040", mem_address); end
      n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL churn_read got %b exp 1", mem_read); end
      mem_resp = 1; mem_rdata = 128'h77;
      tick();
      mem_resp = 0;
      n_chk++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL churn_resp got %b exp 1", i_resp); end
      tick();
      i_read = 0;
      tick();
   endtask

   task automatic test_rw_both();
      d_read = 1; d_write = 1;
      d_address = 16'h0400; d_wdata = 128'h5555;
      tick();
      n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rw_write got %b exp 1", mem_write); end
      n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rw_read got %b exp 0", mem_read); end
      n_chk++; if (mem_wdata !== 128'h5555) begin n_fail++; $display("FAIL rw_wdata got %h exp 5555", mem_wdata); end
      mem_resp = 1; mem_rdata = 128'hDEAD;
      tick();
      mem_resp = 0;
      n_chk++; if (d_resp !== 1'b1) begin n_fail++; $display("FAIL rw_resp got %b exp 1", d_resp); end
      n_chk++; if (d_rdata !== 128'hBEEF) begin n_fail++; $display("FAIL rw_d_rdata got %h exp beef", d_rdata); end
      tick();
      d_read = 0; d_write = 0;
      tick();
   endtask

   task automatic test_reset_busy();
      d_read = 1; d_address = 16'h0500;
      tick();
      n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rb_busy got %b exp 1", mem_read); end
      #2 rst_n = 0;
      #1;
      n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rb_async_read got %b exp 0", mem_read); end
      n_chk++; if (mem_address !== '0) begin n_fail++; $display("FAIL rb_async_addr got %h exp 0", mem_address); end
      n_chk++; if (d_rdata !== '0) begin n_fail++; $display("FAIL rb_async_rdata got %h exp 0", d_rdata); end
      n_chk++; if (i_rdata !== '0) begin n_fail++; $display("FAIL rb_async_irdata got %h exp 0", i_rdata); end
      mem_resp = 1; mem_rdata = 128'h99;
      tick();
      mem_resp = 0;
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL rb_no_resp got %b exp 0", d_resp); end
      tick();
      rst_n = 1;
      n_chk++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL rb_no_resp2 got %b exp 0", d_resp); end
      tick();
      n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rb_reserve got %b exp 1", mem_read); end
      n_chk++; if (mem_address !== 16'h0500) begin n_fail++; $display("FAIL rb_addr got %h exp 0500", mem_address); end
      mem_resp = 1; mem_rdata = 128'h99;
      tick();
      mem_resp = 0;
      n_chk++; if (d_resp !== 1'b1) begin n_fail++; $display("FAIL rb_resp got %b exp 1", d_resp); end
      n_chk++; if (d_rdata !== 128'h99) begin n_fail++; $display("FAIL rb_rdata got %h exp 99", d_rdata); end
      tick();
      d_read = 0;
      tick();
   endtask

   task automatic test_random();
      bit            pi, pd, wi, wd, last_d, gd, opw;
      int            mi, md, lat;
      logic [AW-1:0] ai, ad, ea;
      logic [LW-1:0] wdi, wdd, ri, rd, ew, rdat;
      do_reset();
      last_d = 1; pi = 0; pd = 0; wi = 0; wd = 0; mi = 0; md = 0;
      ai = '0; ad = '0; wdi = '0; wdd = '0; ri = '0; rd = '0;
      for (int t = 0; t < 80; t++) begin
         if (!pi && $urandom_range(0, 2) != 0) begin
            pi = 1; mi = $urandom_range(0, 2); wi = (mi != 0);
            ai = AW'($urandom);
            wdi = {$urandom, $urandom, $urandom, $urandom};
         end
         if (!pd && $urandom_range(0, 2) != 0) begin
            pd = 1; md = $urandom_range(0, 2); wd = (md != 0);
            ad = AW'($urandom);
            wdd = {$urandom, $urandom, $urandom, $urandom};
         end
         i_read = pi && mi != 1; i_write = pi && mi != 0;
         d_read = pd && md != 1; d_write = pd && md != 0;
         i_address = ai; i_wdata = wdi;
         d_address = ad; d_wdata = wdd;
         if (!pi && !pd) begin
            tick();
            continue;
         end
         gd = pd && (!pi || !last_d);
         opw = gd ? wd : wi;
         ea = gd ? ad : ai;
         ew = gd ? wdd : wdi;
         lat = $urandom_range(0, 3);
         rdat = {$urandom, $urandom, $urandom, $urandom};
         tick();
         for (int k = 0; k <= lat; k++) begin
            n_chk++; if (mem_read !== !opw || mem_write !== opw) begin n_fail++; $display("FAIL rnd_op t=%0d got r%b w%b exp w%b", t, mem_read, mem_write, opw); end
            n_chk++; if (mem_address !== ea) begin n_fail++; $display("FAIL rnd_addr t=%0d got %h exp %h", t, mem_address, ea); end
            if (opw) begin
               n_chk++; if (mem_wdata !== ew) begin n_fail++; $display("FAIL rnd_wdata t=%0d got %h exp %h", t, mem_wdata, ew); end
            end
            n_chk++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL rnd_early_resp t=%0d got i%b d%b exp 00", t, i_resp, d_resp); end
            mem_resp = (k == lat);
            mem_rdata = rdat;
            tick();
         end
         mem_resp = 0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (!opw) begin
            if (gd) rd = rdat;
            else    ri = rdat;
         end
         n_chk++; if (i_resp !== !gd || d_resp !== gd) begin n_fail++; $display("FAIL rnd_resp t=%0d got i%b d%b exp d%b", t, i_resp, d_resp, gd); end
         n_chk++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rnd_done_mem t=%0d got r%b w%b exp 00", t, mem_read, mem_write); end
         n_chk++; if (i_rdata !== ri) begin n_fail++; $display("FAIL rnd_i_rdata t=%0d got %h exp %h", t, i_rdata, ri); end
         n_chk++; if (d_rdata !== rd) begin n_fail++; $display("FAIL rnd_d_rdata t=%0d got %h exp %h", t, d_rdata, rd); end
         tick();
         n_chk++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL rnd_pulse t=%0d got i%b d%b exp 00", t, i_resp, d_resp); end
         if (gd) pd = 0;
         else    pi = 0;
         last_d = gd;
      end
      clr_inputs();
      tick();
   endtask

   initial begin
      clr_inputs();
      rst_n = 0;
      test_reset();
      test_single_read();
      test_tie();
      test_slow();
      test_churn();
      test_rw_both();
      test_reset_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width on all ports.
REQ-002 Parameter LINE_W, default 128, line data width on all ports.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Ports i_read, i_write  input  1 each  instruction-side line read/write request, held until i_resp.
REQ-006 Port i_address  input  ADDR_W  instruction-side line address.
REQ-007 Port i_wdata  input  LINE_W  instruction-side write line.
REQ-008 Port i_resp  output  1  one-cycle completion pulse to the instruction side.
REQ-009 Port i_rdata  output  LINE_W  registered read line, valid while i_resp=1.
REQ-010 Ports d_read, d_write, d_address, d_wdata, d_resp, d_rdata: data-side equivalents of REQ-005..REQ-009, same widths and directions.
REQ-011 Ports mem_read, mem_write  output  1 each  memory-side request.
REQ-012 Port mem_address  output  ADDR_W; port mem_wdata  output  LINE_W.
REQ-013 Port mem_resp  input  1  memory completion; may assert in the same cycle as the request (zero-latency memory) or any later cycle.
REQ-014 Port mem_rdata  input  LINE_W  memory read line, valid while mem_resp=1.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; a grant register (I or D) selects the served side.
REQ-016 A side is requesting when its read or write is 1; if read and write are both 1, the access is treated as a write.
REQ-017 IDLE: with no side requesting, stay in IDLE; otherwise latch the winner's address, wdata and op (read/write) into internal registers, set grant, go to BUSY.
REQ-018 Arbitration is round-robin: if both sides request in IDLE, grant the side not granted last; if one side requests, grant it.
REQ-019 last_grant updates only on entry to BUSY.
REQ-020 BUSY: drive mem_read/mem_write per latched op, and mem_address/mem_wdata from latched registers.
REQ-021 Requester input changes after the grant cycle have no effect on the memory-side outputs.
REQ-022 BUSY with mem_resp=0: remain in BUSY with outputs unchanged.
REQ-023 BUSY with mem_resp=1: capture mem_rdata into the granted side's rdata register (reads only), go to DONE.
REQ-024 DONE: mem_read=mem_write=0; assert the granted side's resp for exactly one cycle; next state IDLE.
REQ-025 Requesters drop their request in the cycle following resp. A request still asserted in the IDLE after DONE is treated as a new access.
REQ-026 Minimum latency, request first seen in IDLE at cycle 0 with zero-latency memory: memory access in cycle 1, resp in cycle 2, next grant possible in cycle 3.
REQ-027 The non-granted side's resp stays 0 throughout. Its request waits and is guaranteed service at the next IDLE.
REQ-028 In IDLE and DONE, mem_read and mem_write are 0.
REQ-029 i_rdata and d_rdata hold their last captured value between accesses; a write access does not modify them.
REQ-030 No path from mem_resp or mem_rdata to any output is combinational; all outputs are registered or decoded from state and registers only.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE and last_grant=D (so I wins the first tie).
REQ-032 rst_n=0 clears i_resp, d_resp, mem_read, mem_write, mem_address, mem_wdata, i_rdata and d_rdata to 0.
REQ-033 Reset during BUSY or DONE abandons the access; no resp is issued for it, and requests are re-sampled in the first IDLE after rst_n=1.

Verification
REQ-034 Single read: i_read=1, i_address=16'h0040, memory returns 128'hA5 with mem_resp in the same cycle -> mem_read=1 with mem_address=16'h0040 in cycle 1; i_resp=1 with i_rdata=128'hA5 in cycle 2; d_resp=0 throughout.
REQ-035 Tie after reset: i_read and d_write asserted together -> I served first, D served next (mem_write=1 in cycle 4, d_resp in cycle 5). A second tie then grants I.
REQ-036 Slow memory: d_read with mem_resp held 0 for 5 cycles -> mem_read held stable for 6 cycles total; d_resp exactly one cycle after mem_resp.
REQ-037 Input churn: i_address changes to 16'h1230 while in BUSY -> mem_address keeps the latched value until DONE.
REQ-038 Read+write both asserted on d side -> mem_write=1, mem_read=0, and d_rdata unchanged.
REQ-039 rst_n pulled low while in BUSY -> all outputs 0 immediately (before the next clock edge), no resp issued; after release, the held request is served from IDLE.
